// File: rtl/prio_encoder_q.sv
// Registered priority encoder with sticky request capture and a valid/ready output slot.
// Fixed priority (highest index wins) or round-robin arbitration, chosen by MODE.
module prio_encoder_q #(
  parameter int N    = 8,
  parameter int W    = 3,
  parameter int MODE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [W-1:0] out_code,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] pending,
  output logic         lost
);

  if (N < 2 || N > 256) begin : g_bad_n
    $error("prio_encoder_q: N=%0d outside 2..256", N);
  end
  if (N > (2 ** W)) begin : g_bad_w
    $error("prio_encoder_q: N=%0d does not fit in W=%0d bits", N, W);
  end
  if (MODE != 0 && MODE != 1) begin : g_bad_mode
    $error("prio_encoder_q: MODE=%0d must be 0 or 1", MODE);
  end

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic         accept;
  logic         slot_free;
  logic         lost_hit;
  logic [N-1:0] acc_oh;
  logic [N-1:0] sel_src;
  logic [N-1:0] pending_next;
  logic [W-1:0] sel_code;

  // Highest set index; zero when nothing is set.
  function automatic logic [W-1:0] sel_fixed(input logic [N-1:0] src);
    logic [W-1:0] code;
    code = '0;
    for (int i = 0; i < N; i++) begin
      if (src[i]) code = W'(i);
    end
    return code;
  endfunction

  // First set index after p, wrapping modulo N (not 2**W) so odd N works.
  function automatic logic [W-1:0] sel_rr(input logic [N-1:0] src, input logic [W-1:0] p);
    logic [W-1:0] code;
    logic         found;
    int           idx;
    code  = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(p) + k;
      if (idx >= N) idx = idx - N;
      if (!found && src[idx]) begin
        code  = W'(idx);
        found = 1'b1;
      end
    end
    return code;
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    acc_oh       = '0;
    accept       = out_valid & out_ready;
    if (accept) acc_oh = ONE << out_code;
    sel_src      = pending & ~acc_oh;
    pending_next = sel_src | req;
    slot_free    = !out_valid || accept;
    lost_hit     = |(req & pending & ~acc_oh);
  end

  if (MODE == 1) begin : g_rr
    logic [W-1:0] ptr;

    always_ff @(posedge clk) begin
      if (rst) begin
        ptr <= W'(N - 1);
      end else if (accept) begin
        ptr <= out_code;
      end
    end

    assign sel_code = sel_rr(sel_src, ptr);
  end else begin : g_fp
    assign sel_code = sel_fixed(sel_src);
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      pending   <= '0;
      out_valid <= 1'b0;
      out_code  <= '0;
      lost      <= 1'b0;
    end else begin
      pending <= pending_next;
      if (lost_hit) lost <= 1'b1;
      // Under backpressure the presented code is frozen until accepted.
      if (slot_free) begin
        out_valid <= |sel_src;
        out_code  <= sel_code;
      end
    end
  end

  a_stable_under_backpressure: assert property (
    @(posedge clk) disable iff (rst) (out_valid && !out_ready) |=> (out_valid && $stable(out_code))
  );

  a_code_in_range: assert property (
    @(posedge clk) disable iff (rst) out_valid |-> (int'(out_code) < N)
  );

endmodule

// File: tb/tb_prio_encoder_q.sv
// Bench for prio_encoder_q: a fixed-priority and a round-robin instance (N=4, W=2),
// directed stimulus, per-instance expected-code queues drained by a monitor.
module tb_prio_encoder_q;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_fp, req_rr;
  logic         ready_fp, ready_rr;
  logic [W-1:0] code_fp, code_rr;
  logic         valid_fp, valid_rr;
  logic [N-1:0] pend_fp, pend_rr;
  logic         lost_fp, lost_rr;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] q_fp[$];
  logic [W-1:0] q_rr[$];

  always #5 clk = ~clk;

  prio_encoder_q #(.N(N), .W(W), .MODE(0)) u_fp (
    .clk(clk), .rst(rst), .req(req_fp), .out_code(code_fp), .out_valid(valid_fp),
    .out_ready(ready_fp), .pending(pend_fp), .lost(lost_fp)
  );

  prio_encoder_q #(.N(N), .W(W), .MODE(1)) u_rr (
    .clk(clk), .rst(rst), .req(req_rr), .out_code(code_rr), .out_valid(valid_rr),
    .out_ready(ready_rr), .pending(pend_rr), .lost(lost_rr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one cycle; inputs set after this are sampled at the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted code must be the next expected one for that instance.
  always @(negedge clk) begin
    if (!rst && valid_fp && ready_fp) begin
      if (q_fp.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL fp_unexpected: got code %0d with nothing expected", code_fp);
      end else begin
        check("fp_code", 32'(code_fp), 32'(q_fp.pop_front()));
      end
    end
    if (!rst && valid_rr && ready_rr) begin
      if (q_rr.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rr_unexpected: got code %0d with nothing expected", code_rr);
      end else begin
        check("rr_code", 32'(code_rr), 32'(q_rr.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req_fp = '1; req_rr = '1; ready_fp = 1'b0; ready_rr = 1'b0;
    tick(); tick();
    rst = 1'b0; req_fp = '0; req_rr = '0;
    check("rst_pending", 32'(pend_fp), 32'h0);
    check("rst_valid",   32'(valid_fp), 32'h0);
    check("rst_code",    32'(code_fp), 32'h0);
    check("rst_lost",    32'(lost_fp), 32'h0);
    check("rst_rr_pend", 32'(pend_rr), 32'h0);
    tick();
    check("rst_req_ignored", 32'(pend_fp), 32'h0);

    // 1: two requests drained highest first.
    ready_fp = 1'b1; req_fp = 4'b0110;
    q_fp.push_back(2'd2); q_fp.push_back(2'd1);
    tick(); req_fp = '0;
    check("t1_pending", 32'(pend_fp), 32'h6);
    check("t1_valid_lat", 32'(valid_fp), 32'h0);
    tick();
    check("t1_valid2", 32'(valid_fp), 32'h1);
    check("t1_code2",  32'(code_fp), 32'h2);
    tick();
    check("t1_code1",  32'(code_fp), 32'h1);
    tick();
    check("t1_valid_end", 32'(valid_fp), 32'h0);
    check("t1_pend_end",  32'(pend_fp), 32'h0);
    check("t1_lost",      32'(lost_fp), 32'h0);

    // 2: backpressure holds code 3 while a lower request arrives.
    ready_fp = 1'b0; req_fp = 4'b1000;
    q_fp.push_back(2'd3); q_fp.push_back(2'd0);
    tick(); req_fp = '0;
    for (int c = 2; c <= 6; c++) begin
      tick();
      if (c == 3) req_fp = 4'b0001;
      else req_fp = '0;
      check("t2_hold_valid", 32'(valid_fp), 32'h1);
      check("t2_hold_code",  32'(code_fp), 32'h3);
    end
    check("t2_pending", 32'(pend_fp), 32'h9);
    tick(); ready_fp = 1'b1;
    check("t2_code3_at_release", 32'(code_fp), 32'h3);
    tick();
    check("t2_code0", 32'(code_fp), 32'h0);
    check("t2_valid0", 32'(valid_fp), 32'h1);
    tick();
    check("t2_valid_end", 32'(valid_fp), 32'h0);

    // 5: accept and re-request of the same index in one cycle.
    ready_fp = 1'b0; req_fp = 4'b0100;
    q_fp.push_back(2'd2); q_fp.push_back(2'd2);
    tick(); req_fp = '0;
    tick();
    check("t5_code2", 32'(code_fp), 32'h2);
    ready_fp = 1'b1; req_fp = 4'b0100;
    tick(); req_fp = '0;
    check("t5_pend_kept", 32'(pend_fp), 32'h4);
    check("t5_valid_gap", 32'(valid_fp), 32'h0);
    check("t5_no_lost",   32'(lost_fp), 32'h0);
    tick();
    check("t5_again_valid", 32'(valid_fp), 32'h1);
    check("t5_again_code",  32'(code_fp), 32'h2);
    tick();
    check("t5_valid_end", 32'(valid_fp), 32'h0);
    check("t5_pend_end",  32'(pend_fp), 32'h0);
    check("t5_lost_end",  32'(lost_fp), 32'h0);

    // 4: repeat request while pending sets sticky lost.
    ready_fp = 1'b0; req_fp = 4'b0100;
    q_fp.push_back(2'd2);
    tick(); req_fp = '0;
    tick();
    tick(); req_fp = 4'b0100;
    check("t4_lost_before", 32'(lost_fp), 32'h0);
    tick(); req_fp = '0;
    check("t4_lost_set", 32'(lost_fp), 32'h1);
    tick(); ready_fp = 1'b1;
    check("t4_lost_hold", 32'(lost_fp), 32'h1);
    tick();
    check("t4_valid_end", 32'(valid_fp), 32'h0);
    check("t4_pend_end",  32'(pend_fp), 32'h0);
    tick();
    check("t4_lost_sticky", 32'(lost_fp), 32'h1);

    // 3: round-robin order with wrap.
    ready_rr = 1'b1; req_rr = 4'b1111;
    q_rr.push_back(2'd0); q_rr.push_back(2'd1); q_rr.push_back(2'd2);
    q_rr.push_back(2'd3); q_rr.push_back(2'd0);
    tick(); req_rr = '0;
    tick();
    check("t3_code0", 32'(code_rr), 32'h0);
    tick();
    check("t3_code1", 32'(code_rr), 32'h1);
    tick(); req_rr = 4'b0001;
    check("t3_code2", 32'(code_rr), 32'h2);
    tick(); req_rr = '0;
    check("t3_code3", 32'(code_rr), 32'h3);
    tick();
    check("t3_code0_wrap", 32'(code_rr), 32'h0);
    check("t3_valid_wrap", 32'(valid_rr), 32'h1);
    tick();
    check("t3_valid_end", 32'(valid_rr), 32'h0);
    check("t3_pend_end",  32'(pend_rr), 32'h0);
    check("t3_lost",      32'(lost_rr), 32'h0);

    // 6: reset with a presented, unaccepted code on both instances.
    ready_fp = 1'b0; req_fp = 4'b1011;
    ready_rr = 1'b0; req_rr = 4'b0110;
    tick(); req_fp = '0; req_rr = '0;
    tick();
    check("t6_pre_valid", 32'(valid_fp), 32'h1);
    check("t6_pre_code",  32'(code_fp), 32'h3);
    check("t6_pre_pend",  32'(pend_fp), 32'hb);
    check("t6_pre_rr",    32'(code_rr), 32'h1);
    rst = 1'b1; req_fp = '1; req_rr = '1;
    tick();
    rst = 1'b0; req_fp = '0; req_rr = '0;
    check("t6_pend",    32'(pend_fp), 32'h0);
    check("t6_valid",   32'(valid_fp), 32'h0);
    check("t6_code",    32'(code_fp), 32'h0);
    check("t6_lost",    32'(lost_fp), 32'h0);
    check("t6_rr_pend", 32'(pend_rr), 32'h0);
    check("t6_rr_valid", 32'(valid_rr), 32'h0);
    ready_rr = 1'b1; req_rr = 4'b1111;
    q_rr.push_back(2'd0); q_rr.push_back(2'd1); q_rr.push_back(2'd2); q_rr.push_back(2'd3);
    tick(); req_rr = '0;
    tick();
    check("t6_rr_first", 32'(code_rr), 32'h0);
    tick(); tick(); tick();
    tick();
    check("t6_rr_drained", 32'(valid_rr), 32'h0);

    tick();
    check("fp_queue_left", 32'(q_fp.size()), 32'h0);
    check("rr_queue_left", 32'(q_rr.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
